addsub_serial: RTL

Parametrised, digit-serial adder/subtractor with valid/ready handshaking and an accumulate mode. It processes DIGIT bits per clock over WIDTH/DIGIT cycles, reusing one DIGIT-wide carry chain. It produces sum, carry-out, signed-overflow and zero flags. It is the multi-bit, sequential successor to the team's 1-bit add/subtract cell. Subtraction uses the same rule as that cell: b is XORed with the mode bit, and the mode bit is the initial carry-in.

---
 rtl/addsub_serial.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/addsub_serial.sv
// addsub_serial
//   Digit-serial adder/subtractor. An accepted operation is processed DIGIT
//   bits per clock over N = WIDTH/DIGIT cycles through a single DIGIT-wide
//   carry chain. Subtraction inverts b and uses the mode bit as the initial
//   carry-in. In accumulate mode the left operand is the last completed sum.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (a, b, m, acc sampled on accept)
//   a, b                 WIDTH-bit operands (a ignored when acc = 1)
//   m                    0 = add, 1 = subtract (left - b)
//   acc                  1 = left operand is the previous sum
//   out_valid/out_ready  result handshake
//   sum                  WIDTH-bit result, two's-complement wrap
//   cout                 carry out of the MSB (1 = no borrow on subtract)
//   ovf                  signed overflow
//   zero                 sum == 0
module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    input  logic             acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             rst_done;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] l_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] l_next;
    logic [WIDTH-1:0] r_next;
    logic [DIGIT:0]   dsum;
    logic             c_msb;
    logic             last;
    logic             accept;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             ovf_reg;
    logic             zero_reg;

    // rst_done keeps in_ready low on every cycle that follows a reset edge
    // and lets it rise only in the cycle after rst deasserts, without a
    // combinational path from the rst pin to in_ready.
    assign in_ready  = (state == IDLE) && rst_done;
    assign out_valid = (state == DONE);
    assign accept    = in_ready && in_valid;
    assign last      = (cnt == CW'(N - 1));

    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;
    assign zero = zero_reg;

    // One slice of the shared carry chain.
    assign dsum = {1'b0, l_reg[DIGIT-1:0]} + {1'b0, r_reg[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, carry};

    // Carry into the top bit of the slice recovered from sum ^ a ^ b; on the
    // final slice this is the carry into the word MSB. For DIGIT = 1 it
    // reduces to the incoming carry itself.
    assign c_msb = dsum[DIGIT-1] ^ l_reg[DIGIT-1] ^ r_reg[DIGIT-1];

    assign r_next = r_reg >> DIGIT;

    // The left-operand register doubles as the result register: result
    // digits enter at the top as operand digits leave at the bottom, so after
    // N slices it holds the complete sum.
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign l_next = dsum[DIGIT-1:0];
        end else begin : g_multi
            assign l_next = {dsum[DIGIT-1:0], l_reg[WIDTH-1:DIGIT]};
        end
    endgenerate

    // State register with reset priority over every handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rst_done <= 1'b0;
        end else begin
            state    <= state_next;
            rst_done <= 1'b1;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = CALC;
            CALC:    if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Datapath: operand capture on accept, one slice per CALC cycle, and the
    // output registers loaded only on the last slice so they stay stable
    // through DONE, IDLE and the following CALC.
    always_ff @(posedge clk) begin
        if (rst) begin
            l_reg    <= '0;
            r_reg    <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
            zero_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        l_reg <= acc ? sum_reg : a;
                        r_reg <= b ^ {WIDTH{m}};
                        carry <= m;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    l_reg <= l_next;
                    r_reg <= r_next;
                    carry <= dsum[DIGIT];
                    if (last) begin
                        sum_reg  <= l_next;
                        cout_reg <= dsum[DIGIT];
                        ovf_reg  <= c_msb ^ dsum[DIGIT];
                        zero_reg <= (l_next == '0);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
